// File: rtl/ex_slot_sched_if.sv
// ----------------------------------------------------------------------------
// ex_slot_sched_if
// Bundles the configuration port and the scheduled output stream of
// ex_slot_sched.
//   master : configuration writer / stream consumer (drives i_*, reads o_*)
//   slave  : the scheduler itself (reads i_*, drives o_*)
// Signals:
//   i_wr, i_addr[7:0], i_data[9:0] : configuration write port
//   i_start, i_stop                : level-sampled run control
//   o_dv, o_data[7:0]              : scheduled output stream
//   o_busy, o_frame_done, o_err    : status
// ----------------------------------------------------------------------------
interface ex_slot_sched_if;
    logic       i_wr;
    logic [7:0] i_addr;
    logic [9:0] i_data;
    logic       i_start;
    logic       i_stop;
    logic       o_dv;
    logic [7:0] o_data;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_err;

    modport master (
        output i_wr, i_addr, i_data, i_start, i_stop,
        input  o_dv, o_data, o_busy, o_frame_done, o_err
    );

    modport slave (
        input  i_wr, i_addr, i_data, i_start, i_stop,
        output o_dv, o_data, o_busy, o_frame_done, o_err
    );
endinterface : ex_slot_sched_if

// File: rtl/ex_slot_sched.sv
// ----------------------------------------------------------------------------
// ex_slot_sched
// Programmable slot scheduler. A configuration port loads up to DEPTH slot
// entries ({last, valid, data[7:0]}) and a frame repeat count; a start/stop
// FSM then plays the table out one slot per clock, repeating frames as
// programmed (repeat count 0 = forever) and pulsing o_frame_done on the last
// slot of each frame.
// Ports:
//   sclk  : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ex_slot_sched_if.slave (config write, start/stop, output stream,
//           status). All outputs are registered.
// ----------------------------------------------------------------------------
module ex_slot_sched #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [7:0]  RPT_ADDR = 8'h10
) (
    input  logic            sclk,
    input  logic            rst_n,
    ex_slot_sched_if.slave  bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned EW = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e         state_q;
    logic [PW-1:0]  ptr_q;
    logic [EW-1:0]  tbl_q [DEPTH];
    logic [7:0]     rpt_q;
    logic [7:0]     rcnt_q;
    logic           stop_pend_q;
    logic           o_dv_q;
    logic [7:0]     o_data_q;
    logic           o_busy_q;
    logic           o_frame_done_q;
    logic           o_err_q;

    logic [EW-1:0]  cur_entry;
    logic           cur_valid;
    logic           frame_end;
    logic           addr_is_slot;
    logic           addr_is_rpt;
    logic           wr_ok;
    logic           wr_bad;

    // Current slot decode and config write qualification
    always_comb begin
        cur_entry    = tbl_q[ptr_q];
        cur_valid    = cur_entry[8];
        frame_end    = cur_entry[9] || (ptr_q == PW'(DEPTH - 1));
        addr_is_rpt  = (bus.i_addr == RPT_ADDR);
        addr_is_slot = (bus.i_addr < 8'(DEPTH));
        // o_busy_q also covers the single post-frame cycle spent in IDLE
        wr_ok        = bus.i_wr && (state_q == IDLE) && !o_busy_q
                       && (addr_is_rpt || addr_is_slot);
        wr_bad       = bus.i_wr && !wr_ok;
    end

    // Config table, repeat logic and playback FSM
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            rpt_q          <= 8'd1;
            rcnt_q         <= 8'd0;
            stop_pend_q    <= 1'b0;
            o_dv_q         <= 1'b0;
            o_data_q       <= 8'h00;
            o_busy_q       <= 1'b0;
            o_frame_done_q <= 1'b0;
            o_err_q        <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            o_err_q <= wr_bad;

            if (wr_ok) begin
                if (addr_is_rpt) begin
                    rpt_q <= bus.i_data[7:0];
                end else begin
                    tbl_q[bus.i_addr[PW-1:0]] <= bus.i_data;
                end
            end

            case (state_q)
                IDLE: begin
                    o_dv_q         <= 1'b0;
                    o_data_q       <= 8'h00;
                    o_frame_done_q <= 1'b0;
                    o_busy_q       <= 1'b0;
                    stop_pend_q    <= 1'b0;
                    // Stop wins over a simultaneous start
                    if (bus.i_start && !bus.i_stop) begin
                        state_q  <= RUN;
                        ptr_q    <= '0;
                        rcnt_q   <= rpt_q;
                        o_busy_q <= 1'b1;
                    end
                end

                RUN: begin
                    o_busy_q <= 1'b1;
                    o_dv_q   <= cur_valid;
                    o_data_q <= cur_valid ? cur_entry[7:0] : 8'h00;
                    if (frame_end) begin
                        o_frame_done_q <= 1'b1;
                        ptr_q          <= '0;
                        if (rcnt_q != 8'd0) begin
                            rcnt_q <= rcnt_q - 8'd1;
                        end
                        // A stop seen on the last slot still ends this frame
                        if ((rcnt_q == 8'd1) || stop_pend_q || bus.i_stop) begin
                            state_q     <= IDLE;
                            stop_pend_q <= 1'b0;
                        end
                    end else begin
                        o_frame_done_q <= 1'b0;
                        ptr_q          <= ptr_q + PW'(1);
                        if (bus.i_stop) begin
                            stop_pend_q <= 1'b1;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_dv         = o_dv_q;
    assign bus.o_data       = o_data_q;
    assign bus.o_busy       = o_busy_q;
    assign bus.o_frame_done = o_frame_done_q;
    assign bus.o_err        = o_err_q;

endmodule : ex_slot_sched

// File: tb/tb_ex_slot_sched.sv
// ----------------------------------------------------------------------------
// tb_ex_slot_sched
// Scoreboard bench for ex_slot_sched: stimulus pushes the expected per-cycle
// output record into a queue; a monitor pops one record per falling edge and
// compares it. With the queue empty the block must be idle and silent.
// ----------------------------------------------------------------------------
module tb_ex_slot_sched;

    localparam int unsigned DEPTH    = 8;
    localparam logic [7:0]  RPT_ADDR = 8'h10;

    typedef struct packed {
        logic       dv;
        logic [7:0] data;
        logic       fd;
        logic       busy;
        logic       err;
    } exp_t;

    logic sclk;
    logic rst_n;
    exp_t exp_q[$];
    int   checks;
    int   errors;

    ex_slot_sched_if bus();

    ex_slot_sched #(
        .DEPTH    (DEPTH),
        .RPT_ADDR (RPT_ADDR)
    ) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic dv, input logic [7:0] d, input logic fd,
                                 input logic busy, input logic err);
        exp_t e;
        e.dv   = dv;
        e.data = d;
        e.fd   = fd;
        e.busy = busy;
        e.err  = err;
        exp_q.push_back(e);
    endfunction

    // Monitor: one record per cycle while the queue holds expectations
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge sclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("o_dv",         8'(bus.o_dv),         8'(e.dv));
                chk("o_data",       bus.o_data,           e.data);
                chk("o_frame_done", 8'(bus.o_frame_done), 8'(e.fd));
                chk("o_busy",       8'(bus.o_busy),       8'(e.busy));
                chk("o_err",        8'(bus.o_err),        8'(e.err));
            end else begin
                chk("idle_o_dv",    8'(bus.o_dv),         8'd0);
                chk("idle_o_data",  bus.o_data,           8'd0);
                chk("idle_o_fd",    8'(bus.o_frame_done), 8'd0);
                chk("idle_o_busy",  8'(bus.o_busy),       8'd0);
                chk("idle_o_err",   8'(bus.o_err),        8'd0);
            end
        end
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic cfg_wr(input logic [7:0] a, input logic [9:0] d, input logic bad);
        bus.i_wr   = 1'b1;
        bus.i_addr = a;
        bus.i_data = d;
        tick();
        bus.i_wr   = 1'b0;
        if (bad) push(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic write_tbl1(input logic [7:0] rpt);
        cfg_wr(8'h00, 10'h107, 1'b0);
        cfg_wr(8'h01, 10'h000, 1'b0);
        cfg_wr(8'h02, 10'h305, 1'b0);
        cfg_wr(RPT_ADDR, {2'b00, rpt}, 1'b0);
    endtask

    // Start is captured on the next edge; o_busy rises on that edge
    task automatic start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        push(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic void push_frame1();
        push(1'b1, 8'd7, 1'b0, 1'b1, 1'b0);
        push(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        push(1'b1, 8'd5, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic void push_empty_frame(input logic err_first);
        for (int k = 1; k <= 8; k++) begin
            push(1'b0, 8'h00, (k == 8), 1'b1, err_first && (k == 1));
        end
    endfunction

    function automatic void push_idle();
        push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", 8'(exp_q.size()), 8'd0);
            exp_q.delete();
        end
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b1;
        bus.i_wr    = 1'b0;
        bus.i_addr  = 8'h00;
        bus.i_data  = 10'h000;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_o_dv",   8'(bus.o_dv),         8'd0);
        chk("rst_o_data", bus.o_data,           8'd0);
        chk("rst_o_busy", 8'(bus.o_busy),       8'd0);
        chk("rst_o_fd",   8'(bus.o_frame_done), 8'd0);
        chk("rst_o_err",  8'(bus.o_err),        8'd0);
        rst_n = 1'b1;
        tick();

        // Empty table, default repeat 1; write to slot 5 while busy is dropped
        start();
        bus.i_wr   = 1'b1;
        bus.i_addr = 8'h05;
        bus.i_data = 10'h1AA;
        push_empty_frame(1'b1);
        push_idle();
        tick();
        bus.i_wr = 1'b0;
        drain();

        // Illegal address while idle, then replay shows slot 5 untouched
        cfg_wr(8'h20, 10'h1BB, 1'b1);
        tick();
        start();
        push_empty_frame(1'b0);
        push_idle();
        drain();

        // Three-slot frame, repeat 2
        write_tbl1(8'd2);
        tick();
        start();
        push_frame1();
        push_frame1();
        push_idle();
        drain();

        // Repeat forever, stop during slot 2 of frame 4; start mid-run ignored
        cfg_wr(RPT_ADDR, 10'h000, 1'b0);
        tick();
        start();
        for (int f = 0; f < 4; f++) push_frame1();
        push_idle();
        repeat (4) tick();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        repeat (5) tick();
        bus.i_stop = 1'b1;
        tick();
        bus.i_stop = 1'b0;
        drain();

        // Start and stop together in IDLE, then start alone
        cfg_wr(RPT_ADDR, 10'h001, 1'b0);
        tick();
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b1;
        tick();
        bus.i_stop  = 1'b0;
        tick();
        bus.i_start = 1'b0;
        push(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        push_frame1();
        push_idle();
        drain();

        // Reset mid-run right after a frame-done cycle
        cfg_wr(RPT_ADDR, 10'h000, 1'b0);
        tick();
        start();
        push_frame1();
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge sclk);
            #1;
            n++;
        end
        chk("pre_rst_queue", 8'(exp_q.size()), 8'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_o_dv",   8'(bus.o_dv),         8'd0);
        chk("mid_rst_o_data", bus.o_data,           8'd0);
        chk("mid_rst_o_busy", 8'(bus.o_busy),       8'd0);
        chk("mid_rst_o_fd",   8'(bus.o_frame_done), 8'd0);
        chk("mid_rst_o_err",  8'(bus.o_err),        8'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start();
        push_empty_frame(1'b0);
        push_idle();
        drain();

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ex_slot_sched
